// File: rtl/alu_unit.sv
// Registered N-bit integer ALU with NZCV flags; result/flags appear one cycle after issue.
// No handshake or backpressure: a new operation is accepted on every clock.
module alu_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  localparam logic [N-1:0] WIDTH_VAL = N'(N);

  logic [N-1:0]   result_d, result_q;
  logic [3:0]     flags_d, flags_q;
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [2*N-1:0] prod;
  logic           big_shift;
  logic           b_zero;
  logic           c_d, v_d;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign prod      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  assign big_shift = (b >= WIDTH_VAL);
  assign b_zero    = (b == '0);

  always_comb begin
    result_d = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    case (ctrl)
      OP_ADD: begin
        result_d = sum[N-1:0];
        c_d      = sum[N];
        v_d      = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        // diff[N] is the borrow: set exactly when a < b unsigned
        result_d = diff[N-1:0];
        c_d      = diff[N];
        v_d      = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_MOD: begin
        result_d = b_zero ? a : (a % b);
        v_d      = b_zero;
      end
      OP_MUL: begin
        result_d = prod[N-1:0];
        c_d      = |prod[2*N-1:N];
      end
      OP_SHR: result_d = big_shift ? '0 : (a >> b);
      OP_SHL: result_d = big_shift ? '0 : (a << b);
      OP_XOR: result_d = a ^ b;
      OP_SRA: result_d = big_shift ? {N{a[N-1]}} : N'($signed(a) >>> b);
      default: result_d = '0;
    endcase
    flags_d = {result_d[N-1], (result_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit (N=8): arithmetic reference model checked every cycle plus literal vectors.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [3:0] ctrl = 4'd0;
  logic [7:0] result;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_r = 8'd0;
  logic [3:0] exp_f = 4'd0;
  bit         exp_vld = 1'b0;

  alu_unit #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .ctrl   (ctrl),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Reference model in plain integer arithmetic; returns {result, N, Z, C, V}
  function automatic logic [11:0] model(input logic [7:0] av, input logic [7:0] bv,
                                        input logic [3:0] op);
    int ia, ib, sa, sb, r, c, v, t;
    ia = int'(av);
    ib = int'(bv);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    r = 0; c = 0; v = 0;
    case (op)
      4'd0: begin t = ia + ib; r = t % 256; c = (t > 255) ? 1 : 0;
                  v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0; end
      4'd1: begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0;
                  v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0; end
      4'd2: r = ia & ib;
      4'd3: r = ia | ib;
      4'd4: begin r = (ib == 0) ? ia : ia % ib; v = (ib == 0) ? 1 : 0; end
      4'd5: begin t = ia * ib; r = t % 256; c = (t > 255) ? 1 : 0; end
      4'd6: r = (ib >= 8) ? 0 : ia / (1 << ib);
      4'd7: r = (ib >= 8) ? 0 : (ia * (1 << ib)) % 256;
      4'd8: r = ia ^ ib;
      4'd9: r = (ib >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ib) & 255);
      default: r = 0;
    endcase
    model = {r[7:0], (r >= 128) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], v[0]};
  endfunction

  always @(posedge clk) begin
    if (rst) {exp_r, exp_f} <= 12'h000;
    else     {exp_r, exp_f} <= model(a, b, ctrl);
    exp_vld <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("model_result", int'(result), int'(exp_r));
      chk("model_flags", int'(flags), int'(exp_f));
    end
  end

  // Drive one op, let it clock in, then compare against hand-computed literals.
  task automatic vec(input string name, input logic [7:0] av, input logic [7:0] bv,
                     input logic [3:0] op, input logic [7:0] er, input logic [3:0] ef);
    a = av; b = bv; ctrl = op;
    @(posedge clk); #1;
    chk({name, "_result"}, int'(result), int'(er));
    chk({name, "_flags"}, int'(flags), int'(ef));
  endtask

  initial begin
    @(posedge clk); #1;
    chk("reset_result", int'(result), 0);
    chk("reset_flags", int'(flags), 0);

    // Reset overrides a live ADD, then the same op completes once released
    vec("rst_add", 8'd5, 8'd3, 4'd0, 8'd0, 4'b0000);
    rst = 1'b0;
    vec("add_after_rst", 8'd5, 8'd3, 4'd0, 8'd8, 4'b0000);

    vec("add_ff_1",   8'hFF, 8'd1,  4'd0, 8'h00, 4'b0110);
    vec("add_7f_1",   8'h7F, 8'd1,  4'd0, 8'h80, 4'b1001);
    vec("add_80_80",  8'h80, 8'h80, 4'd0, 8'h00, 4'b0111);
    vec("sub_5_3",    8'd5,  8'd3,  4'd1, 8'd2,  4'b0000);
    vec("sub_3_5",    8'd3,  8'd5,  4'd1, 8'hFE, 4'b1010);
    vec("sub_80_1",   8'h80, 8'd1,  4'd1, 8'h7F, 4'b0001);
    vec("and",        8'd5,  8'd3,  4'd2, 8'd1,  4'b0000);
    vec("or",         8'd5,  8'd3,  4'd3, 8'd7,  4'b0000);
    vec("xor",        8'd5,  8'd3,  4'd8, 8'd6,  4'b0000);
    vec("mod_5_3",    8'd5,  8'd3,  4'd4, 8'd2,  4'b0000);
    vec("mod_5_0",    8'd5,  8'd0,  4'd4, 8'd5,  4'b0001);
    vec("mod_7_7",    8'd7,  8'd7,  4'd4, 8'd0,  4'b0100);
    vec("mul_5_3",    8'd5,  8'd3,  4'd5, 8'd15, 4'b0000);
    vec("mul_16_16",  8'd16, 8'd16, 4'd5, 8'd0,  4'b0110);
    vec("mul_20_09",  8'h20, 8'h09, 4'd5, 8'h20, 4'b0010);
    vec("shr_5_1",    8'd5,  8'd1,  4'd6, 8'd2,  4'b0000);
    vec("shr_ff_8",   8'hFF, 8'd8,  4'd6, 8'd0,  4'b0100);
    vec("shl_1_9",    8'd1,  8'd9,  4'd7, 8'd0,  4'b0100);
    vec("shl_81_1",   8'h81, 8'd1,  4'd7, 8'h02, 4'b0000);
    vec("sra_80_1",   8'h80, 8'd1,  4'd9, 8'hC0, 4'b1000);
    vec("sra_90_9",   8'h90, 8'd9,  4'd9, 8'hFF, 4'b1000);
    vec("sra_40_3",   8'h40, 8'd3,  4'd9, 8'h08, 4'b0000);
    vec("sra_7f_200", 8'h7F, 8'd200, 4'd9, 8'h00, 4'b0100);
    vec("rsv_a",      8'd5,  8'd3,  4'hA, 8'd0,  4'b0100);
    vec("rsv_f",      8'hFF, 8'hFF, 4'hF, 8'd0,  4'b0100);

    // Back-to-back sweep over every ctrl code, checked by the model each cycle
    for (int i = 0; i < 160; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 5 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      ctrl = 4'(i % 16);
      @(posedge clk); #1;
    end

    // Mid-stream reset clears state on the next edge
    rst = 1'b1; a = 8'hFF; b = 8'hFF; ctrl = 4'd5;
    @(posedge clk); #1;
    chk("midrst_result", int'(result), 0);
    chk("midrst_flags", int'(flags), 0);
    rst = 1'b0;

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
